// File: rtl/bram_sdp_pipe.sv
// Simple dual-port byte-enable RAM with a registered read pipeline and a zeroing sweep.
// Define BRAM_SDP_COLLISION_BYPASS_EN to forward same-address write lanes into a same-cycle read.
module bram_sdp_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ABITS = 8,
  parameter int unsigned OREG  = 0,
  parameter int          DELAY = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  output logic               busy_o,
  input  logic               wr_i,
  input  logic [WIDTH/8-1:0] wr_bsel_i,
  input  logic [ABITS-1:0]   wr_addr_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic               rd_i,
  input  logic [ABITS-1:0]   rd_addr_i,
  output logic               rd_ack_o,
  output logic [WIDTH-1:0]   rd_data_o
);

  localparam int unsigned NLANE = WIDTH / 8;
  localparam int unsigned DEPTH = 1 << ABITS;

  // DELAY only shapes simulation models; the RTL itself is zero-delay.
  if ((WIDTH % 8) != 0 || DELAY < 0) begin : g_bad_cfg
    $error("bram_sdp_pipe: WIDTH must be a multiple of 8 and DELAY non-negative");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [ABITS-1:0]   cnt_q, cnt_d;
  logic               clr_we_c, wr_acc_c, rd_acc_c;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   rd_word_c, rd_word_q;
  logic               rd_v1_q;
  logic               out_v_c;
  logic [WIDTH-1:0]   out_d_c;

  // Sweep control and port gating.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    wr_acc_c = 1'b0;
    rd_acc_c = 1'b0;
    case (state_q)
      IDLE: begin
        wr_acc_c = wr_i;
        rd_acc_c = rd_i;
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_we_c = 1'b1;
        cnt_d    = ABITS'(cnt_q + 1'b1);
        if (&cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_o  <= (state_d == CLEAR);
    end
  end

  // Read-first array word, optionally merged with a colliding write.
  always_comb begin
    rd_word_c = mem[rd_addr_i];
`ifdef BRAM_SDP_COLLISION_BYPASS_EN
    if (wr_acc_c && (wr_addr_i == rd_addr_i)) begin
      for (int k = 0; k < NLANE; k++) begin
        if (wr_bsel_i[k]) rd_word_c[8*k +: 8] = wr_data_i[8*k +: 8];
      end
    end
`endif
  end

  // Storage is never reset so a reset mid-sweep leaves a partial clear.
  always_ff @(posedge clk_i) begin
    if (clr_we_c) begin
      mem[cnt_q] <= '0;
    end else if (wr_acc_c) begin
      for (int k = 0; k < NLANE; k++) begin
        if (wr_bsel_i[k]) mem[wr_addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
      end
    end
    if (rd_acc_c) rd_word_q <= rd_word_c;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_v1_q <= 1'b0;
    else       rd_v1_q <= rd_acc_c;
  end

  if (OREG != 0) begin : g_oreg
    logic             rd_v2_q;
    logic [WIDTH-1:0] rd_d2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rd_v2_q <= 1'b0;
        rd_d2_q <= '0;
      end else begin
        rd_v2_q <= rd_v1_q;
        if (rd_v1_q) rd_d2_q <= rd_word_q;
      end
    end

    assign out_v_c = rd_v2_q;
    assign out_d_c = rd_d2_q;
  end else begin : g_no_oreg
    assign out_v_c = rd_v1_q;
    assign out_d_c = rd_word_q;
  end

  // Output stage holds the last delivered word between acks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ack_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_ack_o <= out_v_c;
      if (out_v_c) rd_data_o <= out_d_c;
    end
  end

endmodule

// File: tb/tb_bram_sdp_pipe.sv
// Bench for bram_sdp_pipe: OREG=0 and OREG=1 instances share stimulus and are
// scored against a word-array model with a per-edge read-result history.
module tb_bram_sdp_pipe;

  logic        clk;
  logic        rst, clr, wr, rd;
  logic [3:0]  bsel;
  logic [7:0]  waddr, raddr;
  logic [31:0] wdata;
  logic        busy0, ack0, busy1, ack1;
  logic [31:0] data0, data1;

  bram_sdp_pipe #(.WIDTH(32), .ABITS(8), .OREG(0), .DELAY(3)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .busy_o(busy0),
    .wr_i(wr), .wr_bsel_i(bsel), .wr_addr_i(waddr), .wr_data_i(wdata),
    .rd_i(rd), .rd_addr_i(raddr), .rd_ack_o(ack0), .rd_data_o(data0));

  bram_sdp_pipe #(.WIDTH(32), .ABITS(8), .OREG(1), .DELAY(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .busy_o(busy1),
    .wr_i(wr), .wr_bsel_i(bsel), .wr_addr_i(waddr), .wr_data_i(wdata),
    .rd_i(rd), .rd_addr_i(raddr), .rd_ack_o(ack1), .rd_data_o(data1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_m [256];
  int          clr_left;
  bit          hist_v [4096];
  logic [31:0] hist_d [4096];
  int          n;
  logic [31:0] last0, last1;
  int          checks, errors;
  int          busy_cnt;
  logic [31:0] coll_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h at edge %0d", tag, got, exp, n);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (sel[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  // Effect of the coming edge on the model, using the inputs now applied.
  task automatic model_edge();
    hist_v[n+1] = 1'b0;
    if (rst) begin
      clr_left = 0;
    end else if (clr_left > 0) begin
      mem_m[256-clr_left] = '0;
      clr_left--;
    end else begin
      if (rd) begin
        hist_v[n+1] = 1'b1;
        hist_d[n+1] = mem_m[raddr];
`ifdef BRAM_SDP_COLLISION_BYPASS_EN
        if (wr && waddr == raddr) hist_d[n+1] = merge(mem_m[raddr], wdata, bsel);
`endif
      end
      if (wr) mem_m[waddr] = merge(mem_m[waddr], wdata, bsel);
      if (clr) clr_left = 256;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    n++;
    #1;
    if (hist_v[n-1]) last0 = hist_d[n-1];
    if (hist_v[n-2]) last1 = hist_d[n-2];
    chk("busy0", 32'(busy0), 32'(clr_left > 0));
    chk("busy1", 32'(busy1), 32'(clr_left > 0));
    chk("ack0",  32'(ack0),  32'(hist_v[n-1]));
    chk("ack1",  32'(ack1),  32'(hist_v[n-2]));
    chk("data0", data0, last0);
    chk("data1", data1, last1);
  endtask

  // Assert reset between edges and check it takes effect without a clock.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    hist_v[n]   = 1'b0;
    hist_v[n-1] = 1'b0;
    clr_left = 0;
    last0 = '0;
    last1 = '0;
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_ack0",  32'(ack0),  32'd0);
    chk("rst_ack1",  32'(ack1),  32'd0);
    chk("rst_data0", data0, 32'd0);
    chk("rst_data1", data1, 32'd0);
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    wr = 1'b1; waddr = a; wdata = d; bsel = s;
    cycle();
    wr = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; n = 2; clr_left = 0;
    last0 = '0; last1 = '0;
    rst = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0;
    bsel = '0; waddr = '0; raddr = '0; wdata = '0;

    #1;
    async_reset();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Full sweep with random traffic that must be ignored.
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    busy_cnt = busy0 ? 1 : 0;
    for (int i = 0; i < 256; i++) begin
      wr = 1'($urandom); rd = 1'($urandom); bsel = 4'($urandom);
      waddr = 8'($urandom); raddr = 8'($urandom); wdata = $urandom;
      clr = 1'($urandom);
      cycle();
      if (busy0) busy_cnt++;
    end
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
    chk("sweep_busy_cycles", 32'(busy_cnt), 32'd256);

    for (int a = 0; a < 256; a++) begin
      rd = 1'b1; raddr = 8'(a);
      cycle();
    end
    rd = 1'b0;
    repeat (3) cycle();

    // Full-word write then read back.
    write_word(8'h10, 32'hDEADBEEF, 4'hF);
    rd = 1'b1; raddr = 8'h10;
    cycle();
    rd = 1'b0;
    cycle();
    chk("full_wr_ack0", 32'(ack0), 32'd1);
    chk("full_wr_data0", data0, 32'hDEADBEEF);
    cycle();
    chk("full_wr_data1", data1, 32'hDEADBEEF);

    // Single-lane write keeps the other lanes.
    write_word(8'h10, 32'h00005500, 4'b0010);
    rd = 1'b1; raddr = 8'h10;
    cycle();
    rd = 1'b0;
    cycle();
    chk("lane_wr_data0", data0, 32'hDEAD55EF);
    cycle();
    chk("lane_wr_data1", data1, 32'hDEAD55EF);

    // Empty byte select leaves the word alone.
    write_word(8'h10, 32'hFFFFFFFF, 4'b0000);
    rd = 1'b1; raddr = 8'h10;
    cycle();
    rd = 1'b0;
    cycle();
    chk("nosel_data0", data0, 32'hDEAD55EF);

    // Back-to-back reads through the output register.
    write_word(8'h00, 32'h01010101, 4'hF);
    write_word(8'h01, 32'h02020202, 4'hF);
    write_word(8'h02, 32'h03030303, 4'hF);
    rd = 1'b1; raddr = 8'h00;
    cycle();
    raddr = 8'h01;
    cycle();
    chk("oreg_ack1_early", 32'(ack1), 32'd0);
    raddr = 8'h02;
    cycle();
    chk("oreg_first_ack1", 32'(ack1), 32'd1);
    chk("oreg_first_data1", data1, 32'h01010101);
    rd = 1'b0;
    cycle();
    chk("oreg_second_data1", data1, 32'h02020202);
    cycle();
    chk("oreg_third_data1", data1, 32'h03030303);
    cycle();
    chk("oreg_hold_ack1", 32'(ack1), 32'd0);
    chk("oreg_hold_data1", data1, 32'h03030303);

    // Same-address read and write in one cycle.
    write_word(8'h20, 32'h11111111, 4'hF);
`ifdef BRAM_SDP_COLLISION_BYPASS_EN
    coll_exp = 32'h22222222;
`else
    coll_exp = 32'h11111111;
`endif
    wr = 1'b1; waddr = 8'h20; wdata = 32'h22222222; bsel = 4'hF;
    rd = 1'b1; raddr = 8'h20;
    cycle();
    wr = 1'b0; rd = 1'b0;
    cycle();
    chk("collide_data0", data0, coll_exp);
    rd = 1'b1;
    cycle();
    rd = 1'b0;
    cycle();
    chk("collide_after_data0", data0, 32'h22222222);

    // Random traffic on a small address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      wr = 1'($urandom); rd = 1'($urandom); bsel = 4'($urandom);
      waddr = 8'($urandom_range(0, 7)); raddr = 8'($urandom_range(0, 7));
      wdata = $urandom;
      cycle();
    end
    wr = 1'b0; rd = 1'b0;
    repeat (3) cycle();

    // Read in flight when reset hits is dropped.
    rd = 1'b1; raddr = 8'h05;
    cycle();
    rd = 1'b0;
    async_reset();
    cycle();
    rst = 1'b0;
    cycle();
    chk("flight_ack0", 32'(ack0), 32'd0);
    cycle();
    chk("flight_ack1", 32'(ack1), 32'd0);

    // Read issued with clr_i, then reset partway through the sweep.
    write_word(8'h00, 32'hCAFE0001, 4'hF);
    write_word(8'd200, 32'hA5A5A5A5, 4'hF);
    rd = 1'b1; raddr = 8'h00; clr = 1'b1;
    cycle();
    rd = 1'b0; clr = 1'b0;
    cycle();
    chk("preclr_read_data0", data0, 32'hCAFE0001);
    repeat (99) cycle();
    async_reset();
    cycle();
    rst = 1'b0;
    cycle();
    rd = 1'b1; raddr = 8'h00;
    cycle();
    raddr = 8'd200;
    cycle();
    rd = 1'b0;
    chk("partial_addr0", data0, 32'h00000000);
    cycle();
    chk("partial_addr200", data0, 32'hA5A5A5A5);
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_sdp_pipe.md
BRAM_SDP_PIPE -- requirements
Module: bram_sdp_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ABITS, default 8: address width; depth is 2^ABITS words.
REQ-003 The block SHALL have parameter OREG, default 0: 1 adds an output register stage to the read path.
REQ-004 The block SHALL have parameter DELAY, default 3: simulation-only assignment delay.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port clr_i, input, 1 bit: request a sweep that zeroes all memory words.
REQ-008 The block SHALL have port busy_o, output, 1 bit: a clear sweep is in progress.
REQ-009 The block SHALL have port wr_i, input, 1 bit: write strobe.
REQ-010 The block SHALL have port wr_bsel_i, input, WIDTH/8 bits: byte-lane write enables.
REQ-011 The block SHALL have port wr_addr_i, input, ABITS bits: write address.
REQ-012 The block SHALL have port wr_data_i, input, WIDTH bits: write data.
REQ-013 The block SHALL have port rd_i, input, 1 bit: read strobe.
REQ-014 The block SHALL have port rd_addr_i, input, ABITS bits: read address.
REQ-015 The block SHALL have port rd_ack_o, output, 1 bit: rd_data_o is valid this cycle.
REQ-016 The block SHALL have port rd_data_o, output, WIDTH bits: read data.

Function
REQ-017 The FSM SHALL have two states, IDLE and CLEAR; IDLE->CLEAR on clr_i=1 in IDLE; CLEAR->IDLE after the write to address 2^ABITS-1.
REQ-018 In CLEAR, the block SHALL write zero to every byte of addresses 0..2^ABITS-1 in ascending order, one per cycle, taking 2^ABITS cycles.
REQ-019 busy_o SHALL be 1 exactly while the FSM is in CLEAR: from the cycle after clr_i is sampled until the cycle after the last clear write.
REQ-020 clr_i SHALL be ignored while in CLEAR; the sweep does not restart.
REQ-021 While busy_o=1, wr_i and rd_i SHALL be ignored; no memory write, no rd_ack_o.
REQ-022 In IDLE with wr_i=1, each byte lane k with wr_bsel_i[k]=1 SHALL be written from wr_data_i; lanes with wr_bsel_i[k]=0 SHALL keep their value.
REQ-023 wr_i=1 with wr_bsel_i all zero SHALL leave memory unchanged.
REQ-024 A read accepted at edge T (rd_i=1, IDLE) SHALL give rd_ack_o=1 and valid rd_data_o for one cycle after edge T+1 when OREG=0, or after edge T+2 when OREG=1.
REQ-025 Back-to-back reads SHALL be accepted every cycle; rd_ack_o SHALL follow rd_i with the fixed latency and no gaps or reordering.
REQ-026 rd_data_o SHALL hold its last valid value while rd_ack_o=0.
REQ-027 A read accepted in the last cycle of IDLE before CLEAR SHALL still complete with its pre-clear data.
REQ-028 With OREG=1, a write landing between read acceptance and output SHALL NOT alter that read's returned data.
REQ-029 A read and a write to different addresses in the same cycle SHALL both complete independently.

Reset
REQ-030 On rst_i=1, the block SHALL immediately set FSM=IDLE, the sweep counter=0, busy_o=0, rd_ack_o=0, rd_data_o=0, and clear all pipeline valid flags.
REQ-031 Reset SHALL NOT modify memory contents; a reset during CLEAR leaves memory partially cleared, and software reissues clr_i.
REQ-032 A read in flight when rst_i asserts SHALL be discarded; no rd_ack_o is produced for it.

Configuration
REQ-033 Macro BRAM_SDP_COLLISION_BYPASS_EN defined: a same-cycle read and write to the same address SHALL return per-lane merged data, taking enabled lanes from wr_data_i and other lanes from the old word.
REQ-034 Macro BRAM_SDP_COLLISION_BYPASS_EN undefined: a same-cycle read and write to the same address SHALL return the old word (read-first), and the write SHALL still complete.

Verification
REQ-035 The bench SHALL cover: WIDTH=32, ABITS=8, OREG=0, write 0xDEADBEEF @0x10, bsel=4'hF, then read @0x10 -> rd_ack_o one cycle after read edge, rd_data_o=0xDEADBEEF.
REQ-036 The bench SHALL cover: word @0x10=0xDEADBEEF, write 0x00005500 with bsel=4'b0010, read @0x10 -> 0xDEAD55EF.
REQ-037 The bench SHALL cover: OREG=1, reads @0,1,2 on consecutive cycles -> three consecutive acks starting two cycles after the first read edge, data in order.
REQ-038 The bench SHALL cover: pulse clr_i -> busy_o high for 256 cycles, writes and reads ignored during it, then all 256 reads return 0.
REQ-039 The bench SHALL cover: word @0x20=0x11111111, same-cycle write 0x22222222 (bsel=4'hF) and read @0x20 -> 0x22222222 with the macro defined, 0x11111111 without.
REQ-040 The bench SHALL cover: assert rst_i at clear-sweep cycle 100 -> busy_o=0, rd_ack_o=0 immediately; address 0 reads 0, address 200 keeps its pre-clear value.
